// File: rtl/gpio_led_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gpio_led_bank_if
// Description : Register-access bus for gpio_led_bank. One-cycle read/write
//               strobes, 4-bit address, 32-bit data and a one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_led_bank_if;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output wr_en,
        output rd_en,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/gpio_led_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gpio_led_bank
// Description : Register-mapped GPIO / LED bank. Per-channel direction,
//               output value, PWM dimming, synchronised (optionally
//               debounced) inputs and rising-edge interrupts.
//               Optional feature macro: GPIO_DEBOUNCE_EN adds a per-channel
//               stability counter in front of the input/interrupt logic.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_led_bank #(
    parameter int CHANNELS        = 8,
    parameter int PWM_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,
    gpio_led_bank_if.slave           bus,
    input  wire logic [CHANNELS-1:0] gpio_i,
    output logic      [CHANNELS-1:0] gpio_o,
    output logic      [CHANNELS-1:0] gpio_oe,
    output logic                     irq
);

    localparam logic [3:0] c_ADDR_DIR      = 4'd0;
    localparam logic [3:0] c_ADDR_OUT      = 4'd1;
    localparam logic [3:0] c_ADDR_IN       = 4'd2;
    localparam logic [3:0] c_ADDR_PWM_EN   = 4'd3;
    localparam logic [3:0] c_ADDR_IRQ_EN   = 4'd4;
    localparam logic [3:0] c_ADDR_IRQ_STAT = 4'd5;
    localparam logic [3:0] c_ADDR_DUTY_SEL = 4'd6;
    localparam logic [3:0] c_ADDR_DUTY_VAL = 4'd7;
    localparam int         c_SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Reject parameter values the register map cannot represent
    generate
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
            $error("gpio_led_bank: CHANNELS must be in 1..32");
        end
        if (PWM_WIDTH < 1 || PWM_WIDTH > 32) begin : g_bad_pwm_width
            $error("gpio_led_bank: PWM_WIDTH must be in 1..32");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("gpio_led_bank: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [CHANNELS-1:0]  dir_q,      dir_d;
    logic [CHANNELS-1:0]  out_q,      out_d;
    logic [CHANNELS-1:0]  pwm_en_q,   pwm_en_d;
    logic [CHANNELS-1:0]  irq_en_q,   irq_en_d;
    logic [CHANNELS-1:0]  irq_stat_q, irq_stat_d;
    logic [CHANNELS-1:0]  duty_sel_q, duty_sel_d;
    logic [PWM_WIDTH-1:0] duty_q [CHANNELS];
    logic [PWM_WIDTH-1:0] duty_d [CHANNELS];
    logic [PWM_WIDTH-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [CHANNELS-1:0]  sync1_q;
    logic [CHANNELS-1:0]  sync2_q;
    logic [CHANNELS-1:0]  db_prev_q;
    logic [CHANNELS-1:0]  gpio_o_q,   gpio_o_d;
    logic                 irq_q,      irq_d;
    logic                 ack_q,      ack_d;
    logic [31:0]          rdata_q,    rdata_d;

    logic [CHANNELS-1:0]  w_db;
    logic [CHANNELS-1:0]  w_rise;
    logic [CHANNELS-1:0]  w_wdata;
    logic [31:0]          w_sel_ext;
    logic                 w_sel_ok;
    logic [c_SEL_W-1:0]   w_sel_idx;
    logic [31:0]          w_rd_val;

    assign w_wdata   = bus.wdata[CHANNELS-1:0];
    assign w_sel_ext = 32'(duty_sel_q);
    assign w_sel_ok  = (w_sel_ext < 32'(CHANNELS));
    assign w_sel_idx = w_sel_ext[c_SEL_W-1:0];
    assign w_rise    = w_db & ~db_prev_q;

`ifdef GPIO_DEBOUNCE_EN
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CHANNELS-1:0] db_q,     db_d;
    logic [c_CNT_W-1:0]  db_cnt_q [CHANNELS];
    logic [c_CNT_W-1:0]  db_cnt_d [CHANNELS];

    // Accept a new input level only after it has disagreed with the held level for a full run
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + c_CNT_W'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Debounce state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign w_db = db_q;
`else
    assign w_db = sync2_q;
`endif

    // Register writes and interrupt status; a new edge beats a same-cycle clear
    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        pwm_en_d   = pwm_en_q;
        irq_en_d   = irq_en_q;
        duty_sel_d = duty_sel_q;
        duty_d     = duty_q;
        irq_stat_d = irq_stat_q;
        if (bus.wr_en) begin
            case (bus.addr)
                c_ADDR_DIR:      dir_d      = w_wdata;
                c_ADDR_OUT:      out_d      = w_wdata;
                c_ADDR_PWM_EN:   pwm_en_d   = w_wdata;
                c_ADDR_IRQ_EN:   irq_en_d   = w_wdata;
                c_ADDR_IRQ_STAT: irq_stat_d = irq_stat_q & ~w_wdata;
                c_ADDR_DUTY_SEL: duty_sel_d = w_wdata;
                c_ADDR_DUTY_VAL: begin
                    if (w_sel_ok) begin
                        duty_d[w_sel_idx] = bus.wdata[PWM_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
        irq_stat_d = irq_stat_d | (w_rise & irq_en_q);
    end

    // Read multiplexer, zero-extended to the bus width
    always_comb begin
        w_rd_val = '0;
        case (bus.addr)
            c_ADDR_DIR:      w_rd_val[CHANNELS-1:0] = dir_q;
            c_ADDR_OUT:      w_rd_val[CHANNELS-1:0] = out_q;
            c_ADDR_IN:       w_rd_val[CHANNELS-1:0] = w_db;
            c_ADDR_PWM_EN:   w_rd_val[CHANNELS-1:0] = pwm_en_q;
            c_ADDR_IRQ_EN:   w_rd_val[CHANNELS-1:0] = irq_en_q;
            c_ADDR_IRQ_STAT: w_rd_val[CHANNELS-1:0] = irq_stat_q;
            c_ADDR_DUTY_SEL: w_rd_val[CHANNELS-1:0] = duty_sel_q;
            c_ADDR_DUTY_VAL: begin
                if (w_sel_ok) begin
                    w_rd_val[PWM_WIDTH-1:0] = duty_q[w_sel_idx];
                end
            end
            default: ;
        endcase
    end

    // Bus response, PWM counter, pad output and interrupt next-state
    always_comb begin
        ack_d     = bus.wr_en | bus.rd_en;
        rdata_d   = (bus.rd_en && !bus.wr_en) ? w_rd_val : '0;
        pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
        irq_d     = |(irq_stat_q & irq_en_q);
        gpio_o_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            gpio_o_d[i] = pwm_en_q[i] ? (pwm_cnt_q < duty_q[i]) : out_q[i];
        end
    end

    // All block state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q      <= '0;
            out_q      <= '0;
            pwm_en_q   <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            duty_sel_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i] <= '0;
            end
            pwm_cnt_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_prev_q  <= '0;
            gpio_o_q   <= '0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            pwm_en_q   <= pwm_en_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            duty_sel_q <= duty_sel_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            sync1_q    <= gpio_i;
            sync2_q    <= sync1_q;
            db_prev_q  <= w_db;
            gpio_o_q   <= gpio_o_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gpio_o    = gpio_o_q;
    assign gpio_oe   = dir_q;
    assign irq       = irq_q;
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_led_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gpio_led_bank
// Description : Self-checking bench for gpio_led_bank. Directed scenarios plus
//               randomized register/pad traffic checked against a register-
//               level reference model. Honours GPIO_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_led_bank;

    localparam int          CH      = 8;
    localparam int          PW      = 8;
    localparam int          DB      = 16;
    localparam logic [31:0] CH_MASK = 32'h0000_00FF;
`ifdef GPIO_DEBOUNCE_EN
    localparam int          SETTLE  = DB + 8;
`else
    localparam int          SETTLE  = 8;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] gpio_i;
    logic [CH-1:0] gpio_o;
    logic [CH-1:0] gpio_oe;
    logic          irq;

    gpio_led_bank_if bus ();

    gpio_led_bank #(
        .CHANNELS        (CH),
        .PWM_WIDTH       (PW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents only
    logic [31:0] m_dir, m_out, m_pwm, m_ien, m_stat, m_sel, m_in;
    int          m_duty [CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_out = 0; m_pwm = 0; m_ien = 0; m_stat = 0; m_sel = 0; m_in = 0;
        for (int i = 0; i < CH; i++) m_duty[i] = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return m_dir;
            4'd1:    return m_out;
            4'd2:    return m_in;
            4'd3:    return m_pwm;
            4'd4:    return m_ien;
            4'd5:    return m_stat;
            4'd6:    return m_sel;
            4'd7:    return (m_sel < CH) ? 32'(m_duty[m_sel]) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dm;
        dm = d & CH_MASK;
        case (a)
            4'd0: m_dir  = dm;
            4'd1: m_out  = dm;
            4'd3: m_pwm  = dm;
            4'd4: m_ien  = dm;
            4'd5: m_stat = m_stat & ~dm;
            4'd6: m_sel  = dm;
            4'd7: if (m_sel < CH) m_duty[m_sel] = int'(d % (1 << PW));
            default: ;
        endcase
    endtask

    // One bus transaction; checks the ack lands one cycle later and only once
    task automatic bus_access(input logic wr, input logic rd, input logic [3:0] a,
                              input logic [31:0] d, output logic [31:0] got);
        @(negedge clk);
        bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk($sformatf("ack a=%0d", a), 32'(bus.ack), 32'd1);
        got = bus.rdata;
        @(negedge clk);
        chk($sformatf("ack_single a=%0d", a), 32'(bus.ack), 32'd0);
    endtask

    task automatic check_pads();
        logic [31:0] mask;
        mask = ~m_pwm & CH_MASK;
        for (int i = 0; i < CH; i++) if (m_pwm[i] && m_duty[i] == 0) mask[i] = 1'b1;
        chk("gpio_oe", 32'(gpio_oe), m_dir);
        chk("gpio_o", 32'(gpio_o) & mask, m_out & ~m_pwm & mask);
        chk("irq", 32'(irq), 32'(|(m_stat & m_ien)));
    endtask

    task automatic do_op(input logic wr, input logic rd, input logic [3:0] a, input logic [31:0] d);
        logic [31:0] exp, got;
        exp = (rd && !wr) ? model_read(a) : 32'd0;
        bus_access(wr, rd, a, d, got);
        if (wr) model_write(a, d);
        if (rd) chk($sformatf("rdata a=%0d wr=%0b", a, wr), got, exp);
        check_pads();
    endtask

    task automatic set_inputs(input logic [31:0] v);
        @(negedge clk);
        gpio_i = v[CH-1:0];
        repeat (SETTLE) @(negedge clk);
        m_stat = m_stat | ((v & ~m_in) & m_ien);
        m_in   = v & CH_MASK;
        do_op(1'b0, 1'b1, 4'd2, 32'd0);
    endtask

    task automatic pwm_count(input int ch, output int cnt);
        cnt = 0;
        for (int k = 0; k < (1 << PW); k++) begin
            @(negedge clk);
            if (gpio_o[ch]) cnt++;
        end
    endtask

    initial begin
        logic [31:0] got;
        int          cnt;
        int          r;
        logic [3:0]  a;
        logic [31:0] d;

        model_reset();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 4'd0; bus.wdata = 32'd0;
        gpio_i = '0;
        reset  = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("reset_ack", 32'(bus.ack), 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_gpio_o", 32'(gpio_o), 32'd0);
        chk("reset_gpio_oe", 32'(gpio_oe), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Every address reads zero after reset, unmapped included
        for (int i = 0; i < 16; i++) do_op(1'b0, 1'b1, 4'(i), 32'd0);

        // Direction and static output
        do_op(1'b1, 1'b0, 4'd0, 32'hFFFF_FFFF);
        do_op(1'b1, 1'b0, 4'd1, 32'h0000_00A5);
        chk("dir_oe", 32'(gpio_oe), 32'h0000_00FF);
        chk("out_o", 32'(gpio_o), 32'h0000_00A5);

        // PWM duty on channel 2, including the constant-low and near-full ends
        do_op(1'b1, 1'b0, 4'd6, 32'd2);
        do_op(1'b1, 1'b0, 4'd7, 32'd64);
        do_op(1'b1, 1'b0, 4'd3, 32'h0000_0004);
        pwm_count(2, cnt);
        chk("pwm_duty64", 32'(cnt), 32'd64);
        do_op(1'b1, 1'b0, 4'd7, 32'h0000_0100);
        pwm_count(2, cnt);
        chk("pwm_duty0", 32'(cnt), 32'd0);
        do_op(1'b1, 1'b0, 4'd7, 32'h0000_00FF);
        pwm_count(2, cnt);
        chk("pwm_duty255", 32'(cnt), 32'd255);

        // Out-of-range duty index: write dropped, reads as zero
        do_op(1'b1, 1'b0, 4'd6, 32'd9);
        do_op(1'b1, 1'b0, 4'd7, 32'h11);
        do_op(1'b0, 1'b1, 4'd7, 32'd0);
        do_op(1'b1, 1'b0, 4'd6, 32'd2);
        do_op(1'b0, 1'b1, 4'd7, 32'd0);

        // Rising-edge interrupt and write-1-to-clear
        do_op(1'b1, 1'b0, 4'd4, 32'h1);
        set_inputs(32'h1);
        do_op(1'b0, 1'b1, 4'd5, 32'd0);
        chk("edge_irq_set", 32'(irq), 32'd1);
        do_op(1'b1, 1'b0, 4'd5, 32'h1);
        chk("edge_irq_clr", 32'(irq), 32'd0);

        // Simultaneous read and write performs the write only
        do_op(1'b1, 1'b1, 4'd1, 32'h3C);
        do_op(1'b0, 1'b1, 4'd1, 32'd0);
        chk("rw_out", 32'(gpio_o) & ~m_pwm, 32'h3C & ~m_pwm);

        // Writes to IN and unmapped addresses are ignored
        do_op(1'b1, 1'b0, 4'd2, 32'hFFFF_FFFF);
        do_op(1'b1, 1'b0, 4'd12, 32'hFFFF_FFFF);
        do_op(1'b0, 1'b1, 4'd2, 32'd0);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                set_inputs($urandom & CH_MASK);
            end else begin
                a = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) a = 4'($urandom_range(0, 7));
                d = $urandom;
                if (a == 4'd6) d = 32'($urandom_range(0, 11));
                case ($urandom_range(0, 4))
                    0, 1:    do_op(1'b1, 1'b0, a, d);
                    2, 3:    do_op(1'b0, 1'b1, a, d);
                    default: do_op(1'b1, 1'b1, a, d);
                endcase
            end
        end

`ifdef GPIO_DEBOUNCE_EN
        // A short glitch restarts the stability count
        do_op(1'b1, 1'b0, 4'd4, 32'd0);
        set_inputs(32'd0);
        @(negedge clk);
        gpio_i[0] = 1'b1;
        repeat (5) @(negedge clk);
        gpio_i[0] = 1'b0;
        repeat (3) @(negedge clk);
        gpio_i[0] = 1'b1;
        repeat (12) @(negedge clk);
        bus_access(1'b0, 1'b1, 4'd2, 32'd0, got);
        chk("debounce_early", 32'(got[0]), 32'd0);
        repeat (10) @(negedge clk);
        bus_access(1'b0, 1'b1, 4'd2, 32'd0, got);
        chk("debounce_late", 32'(got[0]), 32'd1);
        m_in = 32'h1;
`endif

        // Reset in the cycle after a write strobe kills the ack and clears outputs
        do_op(1'b1, 1'b0, 4'd0, 32'hFF);
        do_op(1'b1, 1'b0, 4'd3, 32'h0);
        do_op(1'b1, 1'b0, 4'd1, 32'hFF);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.addr = 4'd1; bus.wdata = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.wr_en = 1'b0;
        #1;
        chk("midreset_ack", 32'(bus.ack), 32'd0);
        chk("midreset_rdata", bus.rdata, 32'd0);
        chk("midreset_gpio_o", 32'(gpio_o), 32'd0);
        chk("midreset_gpio_oe", 32'(gpio_oe), 32'd0);
        chk("midreset_irq", 32'(irq), 32'd0);
        model_reset();
        gpio_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_no_ack", 32'(bus.ack), 32'd0);
        do_op(1'b0, 1'b1, 4'd1, 32'd0);
        do_op(1'b0, 1'b1, 4'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
